// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: occupancy states and bubble constants shared by pipeline stages
package pipe_stage_skid_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
  localparam logic [63:0] IF_ID_BUBBLE = {32'h0, RV32_NOP};
endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign value_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with a 2-entry skid buffer, flush and stall/flush counters
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  occ_e              state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d, skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;
  assign out_valid_o = state_q != EMPTY;
  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_o & out_ready_i;
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      out_d   = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          out_d   = in_data_i;
          state_d = ONE;
        end
        ONE: if (push && pop) out_d = in_data_i;
        else if (push) begin
          skid_d  = in_data_i;
          state_d = TWO;
        end else if (pop) begin
          out_d   = BUBBLE_VAL;
          state_d = EMPTY;
        end
        TWO: if (pop) begin
          out_d   = skid_q;
          skid_d  = BUBBLE_VAL;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = state_d != TWO;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q    <= EMPTY;
      out_q      <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  assign in_ready_o = in_ready_q;
  assign out_data_o = out_q;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (!flush_i && out_valid_o && !out_ready_i),
    .value_o(stall_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (flush_i && state_q != EMPTY),
    .value_o(flush_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed streaming, backpressure, flush, saturation and async reset checks
module tb_pipe_stage_skid;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam logic [DW-1:0] BUB = 64'h13;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, flush = 0;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;
  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .flush_i(flush), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic v, input logic [DW-1:0] d, input logic r,
                      input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    check({tag, ".valid"}, DW'(out_valid), DW'(v));
    check({tag, ".data"}, out_data, d);
    check({tag, ".ready"}, DW'(in_ready), DW'(r));
    check({tag, ".stall"}, DW'(stall_cnt), DW'(sc));
    check({tag, ".flush"}, DW'(flush_cnt), DW'(fc));
  endtask
  initial begin
    #12;
    outs("reset", 0, BUB, 1, 0, 0);
    @(negedge clk) rst_n = 1;
    step();
    outs("idle", 0, BUB, 1, 0, 0);
    out_ready = 1; in_valid = 1; in_data = 'h11;
    step(); outs("s1", 1, 'h11, 1, 0, 0);
    in_data = 'h22;
    step(); outs("s2", 1, 'h22, 1, 0, 0);
    in_data = 'h33;
    step(); outs("s3", 1, 'h33, 1, 0, 0);
    in_valid = 0;
    step(); outs("s_drain", 0, BUB, 1, 0, 0);
    step(); outs("empty_ready", 0, BUB, 1, 0, 0);
    out_ready = 0; in_valid = 1; in_data = 'hA;
    step(); outs("bp1", 1, 'hA, 1, 0, 0);
    in_data = 'hB;
    step(); outs("bp2", 1, 'hA, 0, 1, 0);
    in_data = 'hD;
    step(); outs("bp_hold", 1, 'hA, 0, 2, 0);
    in_valid = 0; out_ready = 1;
    step(); outs("bp_popA", 1, 'hB, 1, 2, 0);
    step(); outs("bp_popB", 0, BUB, 1, 2, 0);
    out_ready = 0; in_valid = 1; in_data = 'h1;
    step(); outs("f_fill1", 1, 'h1, 1, 2, 0);
    in_data = 'h2;
    step(); outs("f_fill2", 1, 'h1, 0, 3, 0);
    flush = 1; in_data = 'hC;
    step(); outs("f_full", 0, BUB, 1, 3, 1);
    flush = 0; in_valid = 0; out_ready = 1;
    step(); outs("f_after", 0, BUB, 1, 3, 1);
    flush = 1;
    step(); outs("f_empty", 0, BUB, 1, 3, 1);
    flush = 0; out_ready = 0; in_valid = 1; in_data = 'h7;
    step(); outs("sat_push", 1, 'h7, 1, 3, 1);
    in_valid = 0;
    for (int i = 0; i < 20; i++) step();
    outs("sat", 1, 'h7, 1, 15, 1);
    in_valid = 1; in_data = 'h8;
    step(); outs("r_two", 1, 'h7, 0, 15, 1);
    #2 rst_n = 0;
    #1 outs("r_async", 0, BUB, 1, 0, 0);
    in_data = 'h5;
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    step(); outs("r_push5", 1, 'h5, 1, 0, 0);
    in_valid = 0;
    step(); outs("r_drain", 0, BUB, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
